dcache_req_arbiter: RTL and testbench
=====================================

# dcache_req_arbiter

Shares the single data-cache request port between the two memory pipeline slots (d1 older, d2 younger) downstream of address translation. It arbitrates translated requests onto the dcache interface and holds a grant stable until the cache accepts it. It tracks accepted-but-unanswered transactions in an in-order ID queue so that each `dcache_data_ok` is routed back to the slot that issued it.

## Interface
Parameters:
- `DEPTH`, default 4: maximum outstanding dcache transactions. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `d1_valid`, `d2_valid`  in  1  slot request.
- `d1_we`, `d2_we`  in  1  write.
- `d1_size`, `d2_size`  in  2  access size.
- `d1_wstrb`, `d2_wstrb`  in  4  byte strobes.
- `d1_pa`, `d2_pa`  in  32  physical address.
- `d1_wdata`, `d2_wdata`  in  32  store data.
- `d1_uncached`, `d2_uncached`  in  1  strongly-ordered uncached access.
- `d1_addr_ok`, `d2_addr_ok`  out  1  request accepted this cycle.
- `d1_data_ok`, `d2_data_ok`  out  1  response for this slot this cycle.
- `d1_rdata`, `d2_rdata`  out  32  load data, valid with `dN_data_ok`.
- `dcache_req`, `dcache_wr`  out  1  cache request and write.
- `dcache_size`  out  2  access size to the cache.
- `dcache_wstrb`  out  4  byte strobes to the cache.
- `dcache_addr`, `dcache_wdata`  out  32  address and store data to the cache.
- `dcache_uncached`  out  1  uncached flag to the cache.
- `dcache_addr_ok`, `dcache_data_ok`  in  1  cache handshakes.
- `dcache_rdata`  in  32  cache read data.

## Operation
- Grant states:
  - IDLE: no held grant.
  - HOLD_D1: grant held on d1.
  - HOLD_D2: grant held on d2.
- In IDLE, d1 wins when both slots are valid (program order). Otherwise the sole valid slot wins.
- If a granted request is not accepted (`dcache_req && !dcache_addr_ok`), the state moves to HOLD_Dn. The grant stays on that slot until `dcache_addr_ok`, then returns to IDLE.
- If the held slot drops its valid while in HOLD (pipeline cancel), the state returns to IDLE. No request is issued for it.
- dcache request fields are a combinational mux of the granted slot. `dcache_req = granted valid && !blocked`.
- `dN_addr_ok = grant==N && dcache_req && dcache_addr_ok`.
- ID queue: DEPTH entries, 1 bit each (0 = d1, 1 = d2). Pointers and count are `$clog2(DEPTH)+1` bits wide; the pointers wrap modulo DEPTH.
  - Push on `dcache_req && dcache_addr_ok`.
  - Pop on `dcache_data_ok` while the queue is non-empty.
  - Simultaneous push and pop leaves the count unchanged.
- Writes also return `dcache_data_ok` and consume a queue entry.
- `dN_data_ok = dcache_data_ok && !empty && head==N`.
- `dN_rdata = dcache_rdata`, unconditionally.
- A `dcache_data_ok` with the queue empty is ignored; no output asserts.
- Blocking conditions:
  - The queue is full (count==DEPTH).
  - The granted request is uncached and the count is non-zero. Uncached accesses issue only with nothing outstanding.
- Reset: state IDLE, pointers 0, count 0. All `*_ok` and `dcache_req` are 0 while `reset` is low. In-flight responses are discarded.

## Timing
- Zero-latency request path: `dN_valid` to `dcache_req` is combinational, and `dN_addr_ok` asserts in the same cycle as `dcache_addr_ok`.
- The response path is combinational from `dcache_data_ok`, with the head entry registered.
- The earliest same-slot back-to-back issue is every cycle, provided the queue is not full.
- A pushed entry is visible at the head from the next cycle. A `data_ok` in the same cycle as its own push is not possible and is treated as empty.
- Grant changes take effect only at IDLE. A slot in HOLD is never preempted by the other slot.

## Configuration
- `DCACHE_ARB_FULL_BYPASS_EN`
  - Defined: when count==DEPTH and a pop occurs in the same cycle, the full block is lifted and a new request may issue. Push and pop then happen together.
  - Undefined: full always blocks, so peak throughput at full is one issue every other cycle.

## Test plan
- Both slots valid, `dcache_addr_ok`=1 → cycle 0 grants d1 (`d1_addr_ok`=1, `dcache_addr`=`d1_pa`); cycle 1 grants d2; queue content [0,1].
- d1 valid, `dcache_addr_ok`=0 for 3 cycles while d2 also valid → state HOLD_D1, `dcache_addr` stays `d1_pa`, `d2_addr_ok`=0; accept on cycle 3, then d2 granted.
- Issue d1, d2, d1 (DEPTH=4), then 3× `dcache_data_ok` with rdata 0xA,0xB,0xC → `d1_data_ok` with 0xA, `d2_data_ok` with 0xB, `d1_data_ok` with 0xC, count 0.
- Fill 4 outstanding, keep d1 valid, then pulse `data_ok` with `addr_ok`=1 → without the macro `dcache_req`=0 that cycle; with the macro issue occurs and count stays 4.
- Uncached d2 request with 1 outstanding → `dcache_req`=0 until the pop, then issues the next cycle; a stray `data_ok` on an empty queue → no `dN_data_ok`.
- Assert `reset`=0 with 2 outstanding and state HOLD_D2 → all outputs 0; after release, a `data_ok` is ignored and the state is IDLE.

Source files
------------

// File: rtl/dcache_req_arbiter.sv
// Arbitrates the d1/d2 memory slots onto the single dcache request port and routes responses back in order.
// Optional: DCACHE_ARB_FULL_BYPASS_EN lets a request issue at full occupancy when a response retires in the same cycle.
module dcache_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d1_valid,
  input  logic        d2_valid,
  input  logic        d1_we,
  input  logic        d2_we,
  input  logic [1:0]  d1_size,
  input  logic [1:0]  d2_size,
  input  logic [3:0]  d1_wstrb,
  input  logic [3:0]  d2_wstrb,
  input  logic [31:0] d1_pa,
  input  logic [31:0] d2_pa,
  input  logic [31:0] d1_wdata,
  input  logic [31:0] d2_wdata,
  input  logic        d1_uncached,
  input  logic        d2_uncached,
  output logic        d1_addr_ok,
  output logic        d2_addr_ok,
  output logic        d1_data_ok,
  output logic        d2_data_ok,
  output logic [31:0] d1_rdata,
  output logic [31:0] d2_rdata,
  output logic        dcache_req,
  output logic        dcache_wr,
  output logic [1:0]  dcache_size,
  output logic [3:0]  dcache_wstrb,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_wdata,
  output logic        dcache_uncached,
  input  logic        dcache_addr_ok,
  input  logic        dcache_data_ok,
  input  logic [31:0] dcache_rdata
);

  // state   | meaning
  // IDLE    | no held grant, arbitrate d1 over d2
  // HOLD_D1 | d1 issued but not accepted, grant pinned to d1
  // HOLD_D2 | d2 issued but not accepted, grant pinned to d2
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_D1 = 2'd1,
    HOLD_D2 = 2'd2
  } state_t;

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state, state_nxt;
  logic [DEPTH-1:0] id_q;
  logic [CW-1:0]    wr_ptr, rd_ptr, count;
  logic             gnt_d1, gnt_d2, gnt_valid, gnt_unc;
  logic             empty, full, full_block, blocked;
  logic             push, pop, head;

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + CW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = dcache_data_ok && !empty;
  assign push  = dcache_req && dcache_addr_ok;

`ifdef DCACHE_ARB_FULL_BYPASS_EN
  assign full_block = full && !pop;
`else
  assign full_block = full;
`endif

  always_comb begin
    head = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == CW'(i)) head = id_q[i];
    end
  end

  // Response side: the registered head entry picks the slot, data passes straight through.
  assign d1_data_ok = pop && !head;
  assign d2_data_ok = pop && head;
  assign d1_rdata   = dcache_rdata;
  assign d2_rdata   = dcache_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    gnt_d1          = 1'b0;
    gnt_d2          = 1'b0;
    dcache_req      = 1'b0;
    dcache_wr       = 1'b0;
    dcache_size     = '0;
    dcache_wstrb    = '0;
    dcache_addr     = '0;
    dcache_wdata    = '0;
    dcache_uncached = 1'b0;
    d1_addr_ok      = 1'b0;
    d2_addr_ok      = 1'b0;

    case (state)
      IDLE: begin
        if (d1_valid)      gnt_d1 = 1'b1;
        else if (d2_valid) gnt_d2 = 1'b1;
      end
      HOLD_D1: gnt_d1 = d1_valid;
      HOLD_D2: gnt_d2 = d2_valid;
      default: ;
    endcase

    gnt_valid = gnt_d1 || gnt_d2;
    gnt_unc   = (gnt_d1 && d1_uncached) || (gnt_d2 && d2_uncached);
    // Uncached accesses are strongly ordered: they wait until nothing is outstanding.
    blocked   = full_block || (gnt_unc && !empty);
    dcache_req = reset && gnt_valid && !blocked;

    if (gnt_d1) begin
      dcache_wr       = d1_we;
      dcache_size     = d1_size;
      dcache_wstrb    = d1_wstrb;
      dcache_addr     = d1_pa;
      dcache_wdata    = d1_wdata;
      dcache_uncached = d1_uncached;
    end else if (gnt_d2) begin
      dcache_wr       = d2_we;
      dcache_size     = d2_size;
      dcache_wstrb    = d2_wstrb;
      dcache_addr     = d2_pa;
      dcache_wdata    = d2_wdata;
      dcache_uncached = d2_uncached;
    end

    d1_addr_ok = gnt_d1 && push;
    d2_addr_ok = gnt_d2 && push;

    case (state)
      IDLE: begin
        if (dcache_req && !dcache_addr_ok) state_nxt = gnt_d1 ? HOLD_D1 : HOLD_D2;
      end
      HOLD_D1: begin
        if (!d1_valid || push) state_nxt = IDLE;
      end
      HOLD_D2: begin
        if (!d2_valid || push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_ptr == CW'(i)) id_q[i] <= gnt_d2;
        end
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Randomized and directed bench for dcache_req_arbiter against a queue-based reference model.
module tb_dcache_req_arbiter;
  localparam int DEPTH = 4;
`ifdef DCACHE_ARB_FULL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        d1_valid, d2_valid, d1_we, d2_we, d1_uncached, d2_uncached;
  logic [1:0]  d1_size, d2_size;
  logic [3:0]  d1_wstrb, d2_wstrb;
  logic [31:0] d1_pa, d2_pa, d1_wdata, d2_wdata;
  logic        d1_addr_ok, d2_addr_ok, d1_data_ok, d2_data_ok;
  logic [31:0] d1_rdata, d2_rdata;
  logic        dcache_req, dcache_wr, dcache_uncached;
  logic [1:0]  dcache_size;
  logic [3:0]  dcache_wstrb;
  logic [31:0] dcache_addr, dcache_wdata;
  logic        dcache_addr_ok, dcache_data_ok;
  logic [31:0] dcache_rdata;

  int errors = 0;
  int checks = 0;

  // Reference model: slot currently holding the grant (0 = none) and outstanding slot ids in order.
  int held = 0;
  int q[$];
  bit exp_req, exp_pop;
  int exp_gnt;

  always #5 clk = ~clk;

  dcache_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .d1_valid(d1_valid), .d2_valid(d2_valid),
    .d1_we(d1_we), .d2_we(d2_we),
    .d1_size(d1_size), .d2_size(d2_size),
    .d1_wstrb(d1_wstrb), .d2_wstrb(d2_wstrb),
    .d1_pa(d1_pa), .d2_pa(d2_pa),
    .d1_wdata(d1_wdata), .d2_wdata(d2_wdata),
    .d1_uncached(d1_uncached), .d2_uncached(d2_uncached),
    .d1_addr_ok(d1_addr_ok), .d2_addr_ok(d2_addr_ok),
    .d1_data_ok(d1_data_ok), .d2_data_ok(d2_data_ok),
    .d1_rdata(d1_rdata), .d2_rdata(d2_rdata),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr),
    .dcache_size(dcache_size), .dcache_wstrb(dcache_wstrb),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_uncached(dcache_uncached),
    .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok),
    .dcache_rdata(dcache_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic eval_and_check();
    int g, hd;
    bit full, unc, blk;
    #1;
    if (held == 1)      g = d1_valid ? 1 : 0;
    else if (held == 2) g = d2_valid ? 2 : 0;
    else                g = d1_valid ? 1 : (d2_valid ? 2 : 0);
    hd      = (q.size() > 0) ? q[0] : 0;
    exp_pop = dcache_data_ok && (q.size() > 0);
    full    = (q.size() == DEPTH);
    unc     = (g == 1) ? d1_uncached : ((g == 2) ? d2_uncached : 1'b0);
    blk     = (full && !(BYPASS && exp_pop)) || (unc && q.size() != 0);
    exp_req = (g != 0) && !blk;
    exp_gnt = g;
    chk("dcache_req", 32'(dcache_req), 32'(exp_req));
    chk("d1_addr_ok", 32'(d1_addr_ok), 32'(exp_req && g == 1 && dcache_addr_ok));
    chk("d2_addr_ok", 32'(d2_addr_ok), 32'(exp_req && g == 2 && dcache_addr_ok));
    chk("d1_data_ok", 32'(d1_data_ok), 32'(exp_pop && hd == 1));
    chk("d2_data_ok", 32'(d2_data_ok), 32'(exp_pop && hd == 2));
    chk("d1_rdata", d1_rdata, dcache_rdata);
    chk("d2_rdata", d2_rdata, dcache_rdata);
    if (exp_req) begin
      chk("dcache_addr",  dcache_addr,  (g == 1) ? d1_pa : d2_pa);
      chk("dcache_wdata", dcache_wdata, (g == 1) ? d1_wdata : d2_wdata);
      chk("dcache_wr",    32'(dcache_wr),    32'((g == 1) ? d1_we : d2_we));
      chk("dcache_size",  32'(dcache_size),  32'((g == 1) ? d1_size : d2_size));
      chk("dcache_wstrb", 32'(dcache_wstrb), 32'((g == 1) ? d1_wstrb : d2_wstrb));
      chk("dcache_unc",   32'(dcache_uncached), 32'(unc));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (exp_pop) q.delete(0);
    if (exp_req && dcache_addr_ok) begin
      q.push_back(exp_gnt);
      held = 0;
    end else if (exp_req) begin
      held = exp_gnt;
    end else if (exp_gnt == 0) begin
      held = 0;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    eval_and_check();
    advance();
  endtask

  task automatic set_slots(input bit v1, input bit v2, input bit u1, input bit u2,
                           input bit aok, input bit dok);
    d1_valid = v1; d2_valid = v2; d1_uncached = u1; d2_uncached = u2;
    dcache_addr_ok = aok; dcache_data_ok = dok;
    d1_pa = $urandom; d2_pa = $urandom; d1_wdata = $urandom; d2_wdata = $urandom;
    d1_we = 1'($urandom); d2_we = 1'($urandom);
    d1_size = 2'($urandom); d2_size = 2'($urandom);
    d1_wstrb = 4'($urandom); d2_wstrb = 4'($urandom);
    dcache_rdata = $urandom;
  endtask

  task automatic rand_cycle(input int p_v, input int p_aok, input int p_dok);
    set_slots($urandom_range(99) < p_v, $urandom_range(99) < p_v,
              $urandom_range(9) == 0, $urandom_range(9) == 0,
              $urandom_range(99) < p_aok, $urandom_range(99) < p_dok);
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_slots(0, 0, 0, 0, 0, 1);
      cycle();
    end
  endtask

  initial begin
    set_slots(1, 1, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(dcache_req), 0);
    chk("rst_d1_addr_ok", 32'(d1_addr_ok), 0);
    chk("rst_d2_addr_ok", 32'(d2_addr_ok), 0);
    chk("rst_d1_data_ok", 32'(d1_data_ok), 0);
    chk("rst_d2_data_ok", 32'(d2_data_ok), 0);
    @(negedge clk);
    reset = 1'b1;

    // Both valid, accepted: d1 then d2 once d1 retires its request.
    set_slots(1, 1, 0, 0, 1, 0); cycle();
    set_slots(0, 1, 0, 0, 1, 0); cycle();
    drain();

    // d1 stalled three cycles with d2 waiting, then accepted.
    for (int i = 0; i < 3; i++) begin
      set_slots(1, 1, 0, 0, 0, 0); cycle();
    end
    set_slots(1, 1, 0, 0, 1, 0); cycle();
    set_slots(0, 1, 0, 0, 1, 0); cycle();
    drain();

    // Fill the queue with d1 issues, then retire and issue in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      set_slots(1, 0, 0, 0, 1, 0); cycle();
    end
    set_slots(1, 0, 0, 0, 1, 1); cycle();
    set_slots(1, 0, 0, 0, 1, 1); cycle();
    drain();

    // Uncached d2 behind one outstanding access, plus a stray response on an empty queue.
    set_slots(1, 0, 0, 0, 1, 0); cycle();
    for (int i = 0; i < 2; i++) begin
      set_slots(0, 1, 0, 1, 1, 0); cycle();
    end
    set_slots(0, 1, 0, 1, 1, 1); cycle();
    set_slots(0, 1, 0, 1, 1, 0); cycle();
    drain();

    // Reset with outstanding accesses and d2 held.
    set_slots(1, 0, 0, 0, 1, 0); cycle();
    set_slots(0, 1, 0, 0, 1, 0); cycle();
    set_slots(0, 1, 0, 0, 0, 0); cycle();
    set_slots(1, 1, 0, 0, 1, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dcache_req), 0);
    chk("mid_rst_d1_addr_ok", 32'(d1_addr_ok), 0);
    chk("mid_rst_d2_addr_ok", 32'(d2_addr_ok), 0);
    chk("mid_rst_d1_data_ok", 32'(d1_data_ok), 0);
    chk("mid_rst_d2_data_ok", 32'(d2_data_ok), 0);
    q.delete();
    held = 0;
    @(negedge clk);
    reset = 1'b1;
    set_slots(0, 0, 0, 0, 0, 1); cycle();
    set_slots(1, 1, 0, 0, 1, 0); cycle();

    for (int i = 0; i < 1500; i++) rand_cycle(70, 60, 30);
    for (int i = 0; i < 1500; i++) rand_cycle(50, 70, 70);
    for (int i = 0; i < 1000; i++) rand_cycle(90, 90, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
